bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter using double-dabble, one bit per clock.
- Sits between the binary event counter and the seven-segment display driver, so the display shows decimal digits instead of hex nibbles.
- Uses a start/busy/done handshake. Holds the last result stable on its outputs until the next conversion completes.

---
 rtl/bcd_converter.sv | 103 ++++++++++
 tb/tb_bcd_converter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// Binary-to-BCD by double-dabble, one input bit per clock; result WIDTH+1 cycles after an accepted start.
// start is ignored while busy (not queued); bcd/overflow hold until the next done pulse.
module bcd_converter #(
    parameter int WIDTH  = 24,
    parameter int DIGITS = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  overflow
);

    localparam int DW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [DW-1:0]    acc_q;
    logic             ovf_acc_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [DW-1:0]    bcd_q;
    logic             overflow_q;

    logic [DW-1:0]    acc_adj_d;

    // Add-3 on every nibble >= 5, all digits in parallel, before the shift.
    always_comb begin
        acc_adj_d = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q   <= bin;
                        acc_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        cnt_q     <= CW'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc_q     <= {acc_adj_d[DW-2:0], shift_q[WIDTH-1]};
                    shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                    // A bit falling off the top digit means the value needs more than DIGITS digits.
                    ovf_acc_q <= ovf_acc_q | acc_adj_d[DW-1];
                    cnt_q     <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_q      <= acc_q;
                    overflow_q <= ovf_acc_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: two instances (8 and 6 digits) against a decimal-arithmetic model.
module tb_bcd_converter;

    localparam int WIDTH = 24;

    logic             CLK = 1'b0;
    logic             nRST = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] bin = '0;

    logic        busy8, done8, ovf8;
    logic [31:0] bcd8;
    logic        busy6, done6, ovf6;
    logic [23:0] bcd6;

    int total = 0;
    int bad   = 0;

    bcd_converter #(.WIDTH(WIDTH), .DIGITS(8)) u_dut8 (
        .CLK(CLK), .nRST(nRST), .start(start), .bin(bin),
        .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8)
    );

    bcd_converter #(.WIDTH(WIDTH), .DIGITS(6)) u_dut6 (
        .CLK(CLK), .nRST(nRST), .start(start), .bin(bin),
        .busy(busy6), .done(done6), .bcd(bcd6), .overflow(ovf6)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_bcd(input longint unsigned v, input int d);
        longint unsigned m;
        logic [31:0]     r;
        m = v;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int d);
        longint unsigned lim;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts cycles since acceptance; result from decimal arithmetic.
    logic        m_busy = 1'b0, m_done = 1'b0, m_ovf8 = 1'b0, m_ovf6 = 1'b0;
    logic [31:0] m_bcd8 = '0, m_bcd6 = '0;
    int          m_left = 0;
    longint unsigned m_val = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_bcd8 <= '0; m_bcd6 <= '0;
            m_ovf8 <= 1'b0; m_ovf6 <= 1'b0; m_left <= 0; m_val <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_val  <= longint'(bin);
                    m_left <= WIDTH + 1;
                    m_busy <= 1'b1;
                end
            end else if (m_left == 1) begin
                m_left <= 0;
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_bcd8 <= ref_bcd(m_val, 8);
                m_bcd6 <= ref_bcd(m_val, 6);
                m_ovf8 <= ref_ovf(m_val, 8);
                m_ovf6 <= ref_ovf(m_val, 6);
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge CLK) begin
        check("busy8", {31'b0, busy8}, {31'b0, m_busy});
        check("done8", {31'b0, done8}, {31'b0, m_done});
        check("bcd8",  bcd8,           m_bcd8);
        check("ovf8",  {31'b0, ovf8},  {31'b0, m_ovf8});
        check("busy6", {31'b0, busy6}, {31'b0, m_busy});
        check("done6", {31'b0, done6}, {31'b0, m_done});
        check("bcd6",  {8'b0, bcd6},   m_bcd6);
        check("ovf6",  {31'b0, ovf6},  {31'b0, m_ovf6});
    end

    // Pulse start with v; optionally pulse a second start with w at cycle ign_at.
    task automatic convert(input logic [WIDTH-1:0] v, input int ign_at, input logic [WIDTH-1:0] w,
                           output int lat, output int busy_cnt);
        @(negedge CLK); #1;
        bin = v; start = 1'b1;
        lat = -1; busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (busy8) busy_cnt++;
            if (done8) begin
                lat = n - 1;
                break;
            end
            if (n == 1) begin #1; start = 1'b0; end
            if (ign_at != 0 && n == ign_at) begin #1; start = 1'b1; bin = w; end
            if (ign_at != 0 && n == ign_at + 1) begin #1; start = 1'b0; bin = ~w; end
        end
        if (lat < 0) check("done_timeout", 32'hFFFF_FFFF, 32'd25);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge CLK);
            if (done8) cnt++;
        end
    endtask

    int lat, bcnt, nd, last_idx, npulse;

    initial begin
        #1 nRST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", {31'b0, busy8}, 32'd0);
        check("rst_bcd",  bcd8,           32'd0);
        #1 nRST = 1'b1;

        convert(24'd0, 0, 24'd0, lat, bcnt);
        check("lat0",  lat,  32'd25);
        check("busy0", bcnt, 32'd25);
        check("bcd0",  bcd8, 32'h00000000);
        check("ovf0",  {31'b0, ovf8}, 32'd0);

        convert(24'hFFFFFF, 0, 24'd0, lat, bcnt);
        check("bcd_ff",   bcd8,         32'h16777215);
        check("ovf_ff",   {31'b0, ovf8}, 32'd0);
        check("bcd6_ff",  {8'b0, bcd6}, 32'h00777215);
        check("ovf6_ff",  {31'b0, ovf6}, 32'd1);

        convert(24'd800000, 0, 24'd0, lat, bcnt);
        check("bcd_800k", bcd8, 32'h00800000);

        convert(24'd999999, 0, 24'd0, lat, bcnt);
        check("bcd6_999999", {8'b0, bcd6}, 32'h00999999);
        check("ovf6_999999", {31'b0, ovf6}, 32'd0);

        convert(24'd1000000, 0, 24'd0, lat, bcnt);
        check("bcd6_1e6", {8'b0, bcd6}, 32'h00000000);
        check("ovf6_1e6", {31'b0, ovf6}, 32'd1);
        check("bcd8_1e6", bcd8, 32'h01000000);

        convert(24'd1234567, 0, 24'd0, lat, bcnt);
        check("bcd6_1234567", {8'b0, bcd6}, 32'h00234567);
        check("ovf6_1234567", {31'b0, ovf6}, 32'd1);

        convert(24'd42, 5, 24'd99, lat, bcnt);
        check("ign_lat", lat,  32'd25);
        check("ign_bcd", bcd8, 32'h00000042);
        count_dones(30, nd);
        check("ign_extra_done", nd, 32'd0);

        // start held high: one result every WIDTH+2 cycles
        @(negedge CLK); #1;
        bin = 24'd123; start = 1'b1;
        last_idx = -1; npulse = 0;
        for (int n = 0; n < 90; n++) begin
            @(negedge CLK);
            if (done8) begin
                check("held_bcd", bcd8, 32'h00000123);
                if (last_idx >= 0) check("held_period", n - last_idx, 32'd26);
                last_idx = n;
                npulse++;
            end
        end
        check("held_pulses", npulse, 32'd3);
        #1 start = 1'b0;
        repeat (30) @(negedge CLK);

        // reset in the middle of a conversion
        @(negedge CLK); #1;
        bin = 24'hFFFFFF; start = 1'b1;
        @(negedge CLK); #1 start = 1'b0;
        repeat (9) @(negedge CLK);
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy8}, 32'd0);
        check("mid_rst_done", {31'b0, done8}, 32'd0);
        check("mid_rst_bcd",  bcd8,           32'd0);
        check("mid_rst_ovf",  {31'b0, ovf8},  32'd0);
        @(negedge CLK); #1 nRST = 1'b1;
        count_dones(30, nd);
        check("post_rst_done", nd, 32'd0);

        convert(24'd7, 0, 24'd0, lat, bcnt);
        check("bcd_7", bcd8, 32'h00000007);
        check("lat_7", lat,  32'd25);

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
